// File: rtl/csi2_axis_packer_if.sv
// AXI4-Stream style word bus between the CSI-2 byte packer and its downstream register stage.
// Carries one 32-bit word per Tvalid && Tready handshake.
// Tuser flags the first word of a frame and Tlast the final word of a line.
// Ports: master drives Tvalid/Tdata/Tkeep/Tuser/Tlast and samples Tready; slave is the mirror.
interface csi2_axis_packer_if;
    logic        Tvalid;
    logic        Tready;
    logic [31:0] Tdata;
    logic [3:0]  Tkeep;
    logic        Tuser;
    logic        Tlast;

    modport master (output Tvalid, Tdata, Tkeep, Tuser, Tlast, input Tready);
    modport slave  (input Tvalid, Tdata, Tkeep, Tuser, Tlast, output Tready);
endinterface

// File: rtl/csi2_axis_packer.sv
// Packs CSI-2 payload bytes into 32-bit words with SOF (Tuser) / EOL (Tlast) marks into a FWFT FIFO.
// Latency: a word completed at edge N is at the FIFO head (Tvalid=1) right after edge N if the FIFO was empty.
// Backpressure: Tready stalls only the FIFO; the byte side never stalls, words arriving at full are dropped (overflow).
// Ports: clk/reset (async active-low); byte_valid/byte_data/byte_last payload stream; frame_start/frame_end
//        short-packet pulses; status_clr clears sticky flags; axis word output; overflow/frame_err sticky
//        flags; fifo_level current occupancy.
module csi2_axis_packer #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      byte_valid,
    input  logic [7:0]                byte_data,
    input  logic                      byte_last,
    input  logic                      frame_start,
    input  logic                      frame_end,
    input  logic                      status_clr,
    csi2_axis_packer_if.master        axis,
    output logic                      overflow,
    output logic                      frame_err,
    output logic [AW:0]               fifo_level
);
    typedef enum logic {IDLE, FRAME} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        user;
        logic        last;
    } entry_t;

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    state_t        state, n_state;
    logic [31:0]   pack, n_pack, lane_pack;
    logic [1:0]    cnt, n_cnt;
    logic          sof_pending;
    logic          push, push_ok, pop, full;
    logic          ferr_set, ovf_set;
    entry_t        push_word;
    entry_t        head;
    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // n filled lanes -> n low keep bits set (n = 1..4)
    function automatic logic [3:0] keep_of(input logic [2:0] n);
        keep_of = 4'((5'd1 << n) - 5'd1);
    endfunction

    // Byte is applied first, then FE/FS. A byte that completes a word leaves cnt at 0, so a
    // coinciding FE finds nothing partial and at most one word is pushed per cycle.
    always_comb begin
        n_state   = state;
        n_pack    = pack;
        n_cnt     = cnt;
        push      = 1'b0;
        push_word = '0;
        ferr_set  = 1'b0;
        lane_pack = pack;
        lane_pack[{cnt, 3'b000} +: 8] = byte_data;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    n_state = FRAME;
                    n_pack  = '0;
                    n_cnt   = '0;
                end
            end
            FRAME: begin
                if (byte_valid) begin
                    if (cnt == 2'd3 || byte_last) begin
                        push           = 1'b1;
                        push_word.data = lane_pack;
                        push_word.keep = keep_of({1'b0, cnt} + 3'd1);
                        push_word.user = sof_pending;
                        push_word.last = byte_last;
                        n_pack         = '0;
                        n_cnt          = '0;
                    end else begin
                        n_pack = lane_pack;
                        n_cnt  = cnt + 2'd1;
                    end
                end
                if (frame_end) begin
                    // FE mid-word: flush what we have as a truncated line end
                    if (n_cnt != 2'd0) begin
                        push           = 1'b1;
                        push_word.data = n_pack;
                        push_word.keep = keep_of({1'b0, n_cnt});
                        push_word.user = sof_pending;
                        push_word.last = 1'b1;
                        ferr_set       = 1'b1;
                    end
                    n_pack  = '0;
                    n_cnt   = '0;
                    n_state = IDLE;
                end
                if (frame_start) begin
                    // FS without a preceding FE is a framing error; FE+FS together is a clean restart
                    if (!frame_end) ferr_set = 1'b1;
                    n_pack  = '0;
                    n_cnt   = '0;
                    n_state = FRAME;
                end
            end
            default: n_state = IDLE;
        endcase
    end

    assign pop     = axis.Tvalid && axis.Tready;
    assign full    = (fifo_level == FULL_LVL);
    assign push_ok = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            pack        <= '0;
            cnt         <= '0;
            sof_pending <= 1'b0;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= n_state;
            pack        <= n_pack;
            cnt         <= n_cnt;
            // a dropped word keeps SOF pending so the frame start is not lost
            sof_pending <= frame_start ? 1'b1 : (push_ok ? 1'b0 : sof_pending);
            overflow    <= ovf_set  | (overflow  & ~status_clr);
            frame_err   <= ferr_set | (frame_err & ~status_clr);
        end
    end

    // FIFO: pointers wrap naturally at DEPTH (power of two); level is kept as an explicit count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_word;
    end

    // head is forced to zero when empty so stale storage never shows on the bus
    assign head        = axis.Tvalid ? mem[rd_ptr] : '0;
    assign axis.Tvalid = (fifo_level != '0);
    assign axis.Tdata  = head.data;
    assign axis.Tkeep  = head.keep;
    assign axis.Tuser  = head.user;
    assign axis.Tlast  = head.last;
endmodule

// File: tb/tb_csi2_axis_packer.sv
module tb_csi2_axis_packer;
    localparam int DEPTH = 16;

    logic       clk;
    logic       reset;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_last;
    logic       frame_start;
    logic       frame_end;
    logic       status_clr;
    logic       overflow;
    logic       frame_err;
    logic [4:0] fifo_level;

    csi2_axis_packer_if axis();

    csi2_axis_packer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .status_clr  (status_clr),
        .axis        (axis),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .fifo_level  (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: a line is a byte queue, the FIFO is a word queue of bounded size.
    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        u;
        logic        l;
    } w_t;

    w_t         mq[$];
    logic [7:0] part[$];
    bit         m_inframe, m_sof, m_ovf, m_ferr;
    int         npop;
    logic       last_user;
    logic [31:0] last_data;

    task automatic model_reset();
        mq.delete();
        part.delete();
        m_inframe = 0;
        m_sof     = 0;
        m_ovf     = 0;
        m_ferr    = 0;
    endtask

    function automatic w_t mkw(input logic last);
        w_t w;
        w.d = '0;
        for (int i = 0; i < part.size(); i++) w.d[8*i +: 8] = part[i];
        w.k = 4'((1 << part.size()) - 1);
        w.u = m_sof;
        w.l = last;
        part.delete();
        return w;
    endfunction

    task automatic model_step();
        w_t w;
        bit have;
        bit pop;
        have = 0;
        w = '0;
        if (status_clr) begin
            m_ovf  = 0;
            m_ferr = 0;
        end
        if (m_inframe) begin
            if (byte_valid) begin
                part.push_back(byte_data);
                if (part.size() == 4 || byte_last) begin
                    w = mkw(byte_last);
                    have = 1;
                end
            end
            if (frame_end) begin
                if (part.size() != 0) begin
                    w = mkw(1'b1);
                    have = 1;
                    m_ferr = 1;
                end
                m_inframe = 0;
            end
            if (frame_start) begin
                if (!frame_end) m_ferr = 1;
                part.delete();
                m_inframe = 1;
            end
        end else if (frame_start) begin
            part.delete();
            m_inframe = 1;
        end
        pop = (mq.size() != 0) && axis.Tready;
        if (pop) mq.delete(0);
        if (have) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(w);
                m_sof = 0;
            end else begin
                m_ovf = 1;
            end
        end
        if (frame_start) m_sof = 1;
    endtask

    // One clock: check DUT against model, advance model, clock, then drop single-cycle pulses.
    task automatic cyc();
        chk("m_level", 64'(fifo_level), 64'(mq.size()));
        chk("m_tvalid", 64'(axis.Tvalid), 64'(mq.size() != 0));
        chk("m_overflow", 64'(overflow), 64'(m_ovf));
        chk("m_frame_err", 64'(frame_err), 64'(m_ferr));
        if (mq.size() != 0)
            chk("m_head", 64'({axis.Tdata, axis.Tkeep, axis.Tuser, axis.Tlast}), 64'(mq[0]));
        if (axis.Tvalid && axis.Tready) begin
            npop++;
            last_user = axis.Tuser;
            last_data = axis.Tdata;
        end
        model_step();
        @(posedge clk);
        #1;
        byte_valid  = 0;
        byte_last   = 0;
        frame_start = 0;
        frame_end   = 0;
        status_clr  = 0;
    endtask

    task automatic send_bytes(input int n, input int base, input bit last_end);
        for (int i = 0; i < n; i++) begin
            byte_valid = 1;
            byte_data  = 8'(base + i);
            byte_last  = last_end && (i == n - 1);
            cyc();
        end
    endtask

    task automatic pulse_fs();
        frame_start = 1;
        cyc();
    endtask

    task automatic pulse_fe();
        frame_end = 1;
        cyc();
    endtask

    task automatic drain(input string nm);
        axis.Tready = 1;
        for (int k = 0; k < 4 * DEPTH && axis.Tvalid; k++) cyc();
        chk(nm, 64'(fifo_level), 64'd0);
    endtask

    typedef struct {
        bit          bv;
        logic [7:0]  bd;
        bit          bl, fs, fe, clr;
        bit          evld;
        logic [31:0] edat;
        logic [3:0]  ekeep;
        bit          eu, el;
        int          elvl;
        bit          eo, ef;
    } vec_t;

    function automatic vec_t row(bit bv, logic [7:0] bd, bit bl, bit fs, bit fe, bit clr,
                                 bit evld, logic [31:0] edat, logic [3:0] ekeep, bit eu, bit el,
                                 int elvl, bit eo, bit ef);
        vec_t v;
        v.bv = bv; v.bd = bd; v.bl = bl; v.fs = fs; v.fe = fe; v.clr = clr;
        v.evld = evld; v.edat = edat; v.ekeep = ekeep; v.eu = eu; v.el = el;
        v.elvl = elvl; v.eo = eo; v.ef = ef;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hd;
        // Line 1: 01..08, Tready=1
        tbl.push_back(row(0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h01, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h02, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h03, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h04, 0, 0, 0, 0, 1, 32'h04030201, 4'hF, 1, 0, 1, 0, 0));
        tbl.push_back(row(1, 8'h05, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h06, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h07, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h08, 1, 0, 0, 0, 1, 32'h08070605, 4'hF, 0, 1, 1, 0, 0));
        tbl.push_back(row(0, 8'h00, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        // 6-byte line AA..AF then a 4-byte line 11..14
        tbl.push_back(row(0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'hAA, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'hAB, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'hAC, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'hAD, 0, 0, 0, 0, 1, 32'hADACABAA, 4'hF, 1, 0, 1, 0, 0));
        tbl.push_back(row(1, 8'hAE, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'hAF, 1, 0, 0, 0, 1, 32'h0000AFAE, 4'h3, 0, 1, 1, 0, 0));
        tbl.push_back(row(1, 8'h11, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h12, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h13, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h14, 1, 0, 0, 0, 1, 32'h14131211, 4'hF, 0, 1, 1, 0, 0));
        tbl.push_back(row(0, 8'h00, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        // Bytes and FE while idle are ignored; then 5 bytes cut short by FE
        tbl.push_back(row(1, 8'h55, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 8'h00, 0, 0, 1, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 8'h00, 0, 1, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h01, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h02, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h03, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(1, 8'h04, 0, 0, 0, 0, 1, 32'h04030201, 4'hF, 1, 0, 1, 0, 0));
        tbl.push_back(row(1, 8'h05, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));
        tbl.push_back(row(0, 8'h00, 0, 0, 1, 0, 1, 32'h00000005, 4'h1, 0, 1, 1, 0, 1));
        tbl.push_back(row(0, 8'h00, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0, 0, 0, 0, 1));
        tbl.push_back(row(0, 8'h00, 0, 0, 0, 1, 0, 32'h0, 4'h0, 0, 0, 0, 0, 0));

        reset = 0;
        byte_valid = 0; byte_data = 0; byte_last = 0;
        frame_start = 0; frame_end = 0; status_clr = 0;
        axis.Tready = 0;
        npop = 0; last_user = 0; last_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(axis.Tvalid), 64'd0);
        chk("rst_tdata", 64'(axis.Tdata), 64'd0);
        chk("rst_tkeep", 64'(axis.Tkeep), 64'd0);
        chk("rst_tuser_tlast", 64'({axis.Tuser, axis.Tlast}), 64'd0);
        chk("rst_flags", 64'({overflow, frame_err}), 64'd0);
        chk("rst_level", 64'(fifo_level), 64'd0);
        reset = 1;

        // Table-driven lines
        axis.Tready = 1;
        for (int i = 0; i < tbl.size(); i++) begin
            byte_valid  = tbl[i].bv;
            byte_data   = tbl[i].bd;
            byte_last   = tbl[i].bl;
            frame_start = tbl[i].fs;
            frame_end   = tbl[i].fe;
            status_clr  = tbl[i].clr;
            cyc();
            chk($sformatf("vec%0d_tvalid", i), 64'(axis.Tvalid), 64'(tbl[i].evld));
            chk($sformatf("vec%0d_level", i), 64'(fifo_level), 64'(tbl[i].elvl));
            chk($sformatf("vec%0d_flags", i), 64'({overflow, frame_err}), 64'({tbl[i].eo, tbl[i].ef}));
            if (tbl[i].evld)
                chk($sformatf("vec%0d_word", i),
                    64'({axis.Tdata, axis.Tkeep, axis.Tuser, axis.Tlast}),
                    64'({tbl[i].edat, tbl[i].ekeep, tbl[i].eu, tbl[i].el}));
        end

        // Overflow: 18 words into a stalled 16-deep FIFO
        axis.Tready = 0;
        pulse_fs();
        send_bytes(72, 1, 1);
        chk("ovf_level", 64'(fifo_level), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        chk("ovf_head", 64'({axis.Tdata, axis.Tuser}), 64'({32'h04030201, 1'b1}));
        pulse_fe();
        npop = 0;
        drain("ovf_drain_level");
        chk("ovf_drain_count", 64'(npop), 64'd16);
        status_clr = 1;
        cyc();
        chk("ovf_clear", 64'(overflow), 64'd0);

        // SOF survives a dropped word
        axis.Tready = 0;
        pulse_fs();
        send_bytes(64, 0, 0);
        pulse_fe();
        pulse_fs();
        send_bytes(4, 8'h80, 1);
        chk("sofdrop_ovf", 64'(overflow), 64'd1);
        axis.Tready = 1;
        cyc();
        axis.Tready = 0;
        send_bytes(4, 8'h90, 1);
        chk("sofdrop_level", 64'(fifo_level), 64'd16);
        drain("sofdrop_drain");
        chk("sofdrop_tuser", 64'({last_data, last_user}), 64'({32'h93929190, 1'b1}));
        pulse_fe();
        status_clr = 1;
        cyc();

        // Push+pop at full, and stall stability
        axis.Tready = 0;
        pulse_fs();
        send_bytes(64, 8'h40, 0);
        chk("full_level", 64'(fifo_level), 64'd16);
        chk("full_ovf", 64'(overflow), 64'd0);
        hd = axis.Tdata;
        for (int i = 0; i < 3; i++) begin
            byte_valid = 1;
            byte_data  = 8'(8'hC0 + i);
            cyc();
            chk($sformatf("stall%0d_tdata", i), 64'(axis.Tdata), 64'(hd));
        end
        axis.Tready = 1;
        byte_valid = 1;
        byte_data  = 8'hC3;
        cyc();
        chk("fullpp_level", 64'(fifo_level), 64'd16);
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        drain("fullpp_drain");
        pulse_fe();

        // Asynchronous reset mid-line with 3 words buffered
        axis.Tready = 0;
        pulse_fs();
        send_bytes(14, 8'h20, 0);
        chk("midrst_pre_level", 64'(fifo_level), 64'd3);
        reset = 0;
        #2;
        chk("midrst_tvalid", 64'(axis.Tvalid), 64'd0);
        chk("midrst_level", 64'(fifo_level), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1;
        axis.Tready = 1;
        pulse_fs();
        send_bytes(4, 8'hA0, 1);
        chk("postrst_word", 64'({axis.Tvalid, axis.Tdata, axis.Tkeep, axis.Tuser, axis.Tlast}),
            64'({1'b1, 32'hA3A2A1A0, 4'hF, 1'b1, 1'b1}));
        pulse_fe();

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            byte_valid  = ($urandom % 4) != 0;
            byte_data   = 8'($urandom);
            byte_last   = byte_valid && (($urandom % 8) == 0);
            frame_start = ($urandom % 64) == 0;
            frame_end   = ($urandom % 48) == 0;
            status_clr  = ($urandom % 32) == 0;
            axis.Tready = ($urandom % 100) < ((k < 1500) ? 80 : 15);
            cyc();
        end
        drain("rand_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/csi2_axis_packer.md
Name: csi2_axis_packer

Overview:
- Upstream neighbour of the AXI4-Stream output register stage in the CSI-2 receive path.
- Consumes the depacketised long-packet payload byte stream and the Frame Start/Frame End short-packet events.
- Packs bytes into 32-bit words and marks start-of-frame (Tuser) and end-of-line (Tlast).
- Buffers words in a small FIFO, because the CSI-2 side cannot be back-pressured.

Parameters:
DEPTH, 16, FIFO depth in words; power of two, minimum 4.
AW, $clog2(DEPTH), FIFO address width; derived, do not override.

Ports:
clk  input  1  single clock; all logic on rising edge.
reset  input  1  asynchronous, active-low reset.
byte_valid  input  1  payload byte strobe.
byte_data  input  8  payload byte.
byte_last  input  1  qualifies byte_valid; marks the final payload byte of a line (long packet).
frame_start  input  1  single-cycle pulse on a decoded FS short packet.
frame_end  input  1  single-cycle pulse on a decoded FE short packet.
status_clr  input  1  pulse; clears the sticky status flags.
Tready  input  1  downstream ready.
Tvalid  output  1  FIFO head valid.
Tdata  output  32  packed word; first byte of the line in [7:0].
Tkeep  output  4  valid byte lanes of Tdata.
Tuser  output  1  first word of a frame.
Tlast  output  1  last word of a line.
overflow  output  1  sticky: a word was dropped because the FIFO was full.
frame_err  output  1  sticky: framing violation.
fifo_level  output  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0; FIFO empty; state IDLE.
  - Packing register and lane counter cleared; sof_pending=0.
  - Reset mid-line discards all buffered and partial data.
- FSM:
  - IDLE: byte_valid ignored (bytes dropped, no flag). frame_end ignored. frame_start -> FRAME with sof_pending=1.
  - FRAME, bytes: each byte_valid writes byte_data into lane[cnt], then cnt increments. A word is pushed when cnt==3 or byte_last=1; cnt then returns to 0.
  - FRAME, pushed word fields: Tkeep = lanes filled (e.g. 3 bytes -> 4'b0111); unused lanes zero; Tlast=byte_last; Tuser=sof_pending. sof_pending clears on a successful push.
  - FRAME, frame_end: if cnt!=0, the partial word is pushed with Tlast=1 and frame_err is set. Then -> IDLE.
  - FRAME, frame_start: the partial word is discarded, frame_err is set, sof_pending=1, and the state stays FRAME.
- Same-cycle events in FRAME:
  - byte_valid together with frame_end or frame_start: the byte is processed first, then the event.
  - If the byte completes a word and frame_end arrives, only one push occurs (the completed word, with Tlast=byte_last), and frame_err is not set.
- FIFO:
  - First-word-fall-through, 38-bit entries (data, keep, user, last).
  - Output signals are driven directly from the head entry; Tvalid = (fifo_level!=0).
  - Pop when Tvalid && Tready.
  - Latency: a word pushed at edge N has Tvalid=1 after edge N when the FIFO was empty.
  - Output fields are stable while Tvalid && !Tready.
- Full/overflow:
  - A push with level==DEPTH and no pop in the same cycle drops the word and sets overflow.
  - sof_pending stays set on a drop, so the next pushed word carries Tuser.
  - A push and pop in the same cycle at full is accepted; level is unchanged and overflow is not set.
  - A push and pop in the same cycle at empty: the pushed word is written and the level becomes 1.
- Pointers wrap modulo DEPTH; fifo_level is a true count, not derived from pointer difference.
- status_clr: clears overflow and frame_err. If a new set event coincides with the clear, the set wins.

Test Plan:
1. FS, 8 bytes 01..08 with byte_last on 08, FE, Tready=1 -> 2 words:
   - word 1: Tdata=0x04030201, Tkeep=F, Tuser=1, Tlast=0;
   - word 2: Tdata=0x08070605, Tkeep=F, Tuser=0, Tlast=1;
   - no flags set.
2. FS, 6-byte line AA..AF with byte_last -> second word Tdata=0x0000AFAE, Tkeep=4'b0011, Tlast=1. Same test: a second 4-byte line -> Tuser=0.
3. Tready=0, DEPTH=16, FS, 72 bytes (18 words):
   - fifo_level saturates at 16 and overflow=1.
   - Release Tready -> exactly 16 words drained, the first with Tuser=1.
   - status_clr -> overflow=0.
4. FS, 5 bytes without byte_last, FE -> second word Tkeep=4'b0001, Tlast=1, frame_err=1. Bytes sent before FS produce no output.
5. Full FIFO with Tready=1 and a push in the same cycle -> level stays 16, overflow stays 0. Backpressure holds Tdata stable across 3 stalled cycles.
6. Assert reset low mid-line with 3 words buffered -> Tvalid=0, fifo_level=0 immediately. After release, the next FS line starts with Tuser=1 and a clean lane count.
